// File: rtl/spu_lbuf.sv
// SPU local buffer: one read and one write port, shared between the SPU and a host DMA port.
// The SPU always wins its port; the host fills idle slots. Reads go through a two-stage pipeline.
module spu_lbuf #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4096
) (
    input  logic                  core_clk,
    input  logic                  rst,
    input  logic                  lbuf_ren,
    input  logic [ADDR_WIDTH-1:0] lbuf_raddr,
    output logic [DATA_WIDTH-1:0] lbuf_rdata,
    input  logic                  lbuf_wen,
    input  logic [ADDR_WIDTH-1:0] lbuf_waddr,
    input  logic [DATA_WIDTH-1:0] lbuf_wdata,
    input  logic                  host_req_valid,
    output logic                  host_req_ready,
    input  logic                  host_req_we,
    input  logic [ADDR_WIDTH-1:0] host_req_addr,
    input  logic [DATA_WIDTH-1:0] host_req_wdata,
    output logic                  host_rsp_valid,
    output logic [DATA_WIDTH-1:0] host_rsp_data,
    output logic                  err,
    input  logic                  err_clr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  host_rd;
    logic                  host_wr;
    logic                  rd_en;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_ok;
    logic                  wr_ok;

    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_host_q, s1_host_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic [DATA_WIDTH-1:0] lbuf_rdata_q, lbuf_rdata_d;
    logic                  host_rsp_valid_q, host_rsp_valid_d;
    logic [DATA_WIDTH-1:0] host_rsp_data_q, host_rsp_data_d;
    logic                  err_q, err_d;

    // No access of any kind is accepted while rst is high.
    assign host_req_ready = ~rst & ~(host_req_we ? lbuf_wen : lbuf_ren);

    assign host_rd = host_req_valid & ~host_req_we & host_req_ready;
    assign host_wr = host_req_valid & host_req_we & host_req_ready;
    assign rd_en   = (lbuf_ren & ~rst) | host_rd;
    assign wr_en   = (lbuf_wen & ~rst) | host_wr;
    assign rd_addr = lbuf_ren ? lbuf_raddr : host_req_addr;
    assign wr_addr = lbuf_wen ? lbuf_waddr : host_req_addr;
    assign wr_data = lbuf_wen ? lbuf_wdata : host_req_wdata;
    assign rd_ok   = {1'b0, rd_addr} < DEPTH_W;
    assign wr_ok   = {1'b0, wr_addr} < DEPTH_W;

    always_comb begin
        s1_valid_d       = rd_en;
        s1_host_d        = host_rd;
        s1_data_d        = '0;
        lbuf_rdata_d     = lbuf_rdata_q;
        host_rsp_valid_d = s1_valid_q & s1_host_q;
        host_rsp_data_d  = host_rsp_data_q;
        err_d            = err_q;

        // Write-first: a same-cycle write to the read address is forwarded.
        if (rd_en && rd_ok) begin
            if (wr_en && wr_ok && (wr_addr == rd_addr)) begin
                s1_data_d = wr_data;
            end else begin
                s1_data_d = mem[rd_addr[IDX_W-1:0]];
            end
        end

        if (s1_valid_q && !s1_host_q) begin
            lbuf_rdata_d = s1_data_q;
        end
        if (s1_valid_q && s1_host_q) begin
            host_rsp_data_d = s1_data_q;
        end

        if (err_clr) begin
            err_d = 1'b0;
        end
        if ((rd_en && !rd_ok) || (wr_en && !wr_ok)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge core_clk) begin
        if (rst) begin
            s1_valid_q       <= 1'b0;
            s1_host_q        <= 1'b0;
            s1_data_q        <= '0;
            lbuf_rdata_q     <= '0;
            host_rsp_valid_q <= 1'b0;
            host_rsp_data_q  <= '0;
            err_q            <= 1'b0;
        end else begin
            s1_valid_q       <= s1_valid_d;
            s1_host_q        <= s1_host_d;
            s1_data_q        <= s1_data_d;
            lbuf_rdata_q     <= lbuf_rdata_d;
            host_rsp_valid_q <= host_rsp_valid_d;
            host_rsp_data_q  <= host_rsp_data_d;
            err_q            <= err_d;
        end
    end

    // Storage is deliberately never reset or initialised.
    always_ff @(posedge core_clk) begin
        if (wr_en && wr_ok) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    assign lbuf_rdata     = lbuf_rdata_q;
    assign host_rsp_valid = host_rsp_valid_q;
    assign host_rsp_data  = host_rsp_data_q;
    assign err            = err_q;

endmodule

// File: tb/tb_spu_lbuf.sv
// Bench for spu_lbuf: directed vectors with literal expectations plus a
// cycle-scheduled reference model checked on every falling edge.
module tb_spu_lbuf;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic          ren;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          hv;
    logic          hready;
    logic          hwe;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hwdata;
    logic          hrvalid;
    logic [DW-1:0] hrdata;
    logic          err;
    logic          err_clr;

    always #5 clk = ~clk;

    spu_lbuf #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .core_clk      (clk),
        .rst           (rst),
        .lbuf_ren      (ren),
        .lbuf_raddr    (raddr),
        .lbuf_rdata    (rdata),
        .lbuf_wen      (wen),
        .lbuf_waddr    (waddr),
        .lbuf_wdata    (wdata),
        .host_req_valid(hv),
        .host_req_ready(hready),
        .host_req_we   (hwe),
        .host_req_addr (haddr),
        .host_req_wdata(hwdata),
        .host_rsp_valid(hrvalid),
        .host_rsp_data (hrdata),
        .err           (err),
        .err_clr       (err_clr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: memory contents plus results scheduled by the
    // edge index at which they must become visible.
    logic [31:0] mmem [int];
    logic [31:0] due_spu [int];
    bit          due_spu_k [int];
    logic [31:0] due_host [int];
    bit          due_host_k [int];
    logic [31:0] e_lbuf, e_hdata;
    bit          e_lbuf_k, e_hdata_k, e_hval, e_err;
    int          k = 0;
    bit          on = 0;

    bit          m_hrd, m_hwr, m_wen, m_ren;
    logic [AW-1:0] m_ra, m_wa;
    logic [31:0] m_wd, m_rv;
    bit          m_rk;

    always @(posedge clk) begin
        k++;
        if (rst) begin
            due_spu.delete();
            due_spu_k.delete();
            due_host.delete();
            due_host_k.delete();
            e_lbuf = 0;
            e_lbuf_k = 1;
            e_hdata = 0;
            e_hdata_k = 1;
            e_hval = 0;
            e_err = 0;
        end else begin
            e_hval = 0;
            if (due_spu_k.exists(k)) begin
                e_lbuf   = due_spu[k];
                e_lbuf_k = due_spu_k[k];
            end
            if (due_host_k.exists(k)) begin
                e_hval    = 1;
                e_hdata   = due_host[k];
                e_hdata_k = due_host_k[k];
            end
            m_hrd = hv && !hwe && !ren;
            m_hwr = hv && hwe && !wen;
            m_wen = wen || m_hwr;
            m_wa  = wen ? waddr : haddr;
            m_wd  = wen ? wdata : hwdata;
            m_ren = ren || m_hrd;
            m_ra  = ren ? raddr : haddr;
            if (m_ren) begin
                m_rk = 1;
                if (m_ra >= DEPTH) m_rv = 0;
                else if (m_wen && m_wa == m_ra) m_rv = m_wd;
                else if (mmem.exists(int'(m_ra))) m_rv = mmem[int'(m_ra)];
                else begin
                    m_rv = 0;
                    m_rk = 0;
                end
                if (ren) begin
                    due_spu[k+1]   = m_rv;
                    due_spu_k[k+1] = m_rk;
                end else begin
                    due_host[k+1]   = m_rv;
                    due_host_k[k+1] = m_rk;
                end
            end
            if (m_wen && m_wa < DEPTH) mmem[int'(m_wa)] = m_wd;
            if (err_clr) e_err = 0;
            if ((m_ren && m_ra >= DEPTH) || (m_wen && m_wa >= DEPTH)) e_err = 1;
        end
    end

    always @(negedge clk) begin
        if (on) begin
            if (e_lbuf_k) chk("m_lbuf_rdata", rdata, e_lbuf);
            chk("m_host_rsp_valid", {31'b0, hrvalid}, {31'b0, e_hval});
            if (e_hdata_k) chk("m_host_rsp_data", hrdata, e_hdata);
            chk("m_err", {31'b0, err}, {31'b0, e_err});
            chk("m_host_req_ready", {31'b0, hready},
                {31'b0, !rst && !(hwe ? wen : ren)});
        end
    end

    initial begin
        rst = 1; ren = 0; raddr = 0; wen = 0; waddr = 0; wdata = 0;
        hv = 0; hwe = 0; haddr = 0; hwdata = 0; err_clr = 0;
        step();
        on = 1;
        step();
        chk("rst_lbuf_rdata", rdata, 32'h0);
        chk("rst_host_rsp_valid", {31'b0, hrvalid}, 32'h0);
        chk("rst_host_rsp_data", hrdata, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        hv = 1; hwe = 0; haddr = 12'h010;
        #1 chk("rst_ready", {31'b0, hready}, 32'h0);
        step();
        hv = 0; rst = 0;
        step();

        // write then read back, value holds
        wen = 1; waddr = 12'h010; wdata = 32'hA5A5_0001;
        step();
        wen = 0; ren = 1; raddr = 12'h010;
        step();
        ren = 0;
        step();
        chk("rd_t2", rdata, 32'hA5A5_0001);
        step();
        chk("rd_t3_hold", rdata, 32'hA5A5_0001);

        // same-cycle write/read bypass
        wen = 1; waddr = 12'h020; wdata = 32'h1234;
        ren = 1; raddr = 12'h020;
        step();
        wen = 0; ren = 0;
        step();
        chk("bypass", rdata, 32'h1234);

        // host read stalled by SPU reads
        hv = 1; hwe = 0; haddr = 12'h010; ren = 1; raddr = 12'h020;
        for (int i = 0; i < 3; i++) begin
            #1 chk("host_stall_ready", {31'b0, hready}, 32'h0);
            step();
        end
        ren = 0;
        #1 chk("host_accept_ready", {31'b0, hready}, 32'h1);
        step();
        hv = 0;
        step();
        chk("host_rsp_pulse", {31'b0, hrvalid}, 32'h1);
        chk("host_rsp_data", hrdata, 32'hA5A5_0001);
        step();
        chk("host_rsp_end", {31'b0, hrvalid}, 32'h0);

        // write in the cycle after a read must not affect that read
        wen = 1; waddr = 12'h030; wdata = 32'h1111;
        step();
        wen = 0; ren = 1; raddr = 12'h030;
        step();
        ren = 0; wen = 1; waddr = 12'h030; wdata = 32'h2222;
        step();
        wen = 0;
        chk("rd_before_wr", rdata, 32'h1111);
        ren = 1; raddr = 12'h030;
        step();
        ren = 0;
        step();
        chk("rd_after_wr", rdata, 32'h2222);

        // out-of-range accesses
        wen = 1; waddr = 12'h000; wdata = 32'h5555;
        step();
        waddr = 12'h400; wdata = 32'hFFFF;
        step();
        wen = 0;
        chk("oob_wr_err", {31'b0, err}, 32'h1);
        ren = 1; raddr = 12'h400;
        step();
        ren = 0;
        step();
        chk("oob_rd_zero", rdata, 32'h0);
        ren = 1; raddr = 12'h000;
        step();
        ren = 0;
        step();
        chk("oob_no_alias", rdata, 32'h5555);
        err_clr = 1;
        step();
        err_clr = 0;
        chk("err_clr", {31'b0, err}, 32'h0);
        hv = 1; hwe = 1; haddr = 12'h7FF; hwdata = 32'h1;
        step();
        chk("host_oob_wr_err", {31'b0, err}, 32'h1);
        err_clr = 1; hwe = 0; haddr = 12'h500;
        step();
        err_clr = 0; hv = 0;
        chk("err_clr_loses", {31'b0, err}, 32'h1);
        step();
        chk("host_oob_rd_valid", {31'b0, hrvalid}, 32'h1);
        chk("host_oob_rd_zero", hrdata, 32'h0);
        err_clr = 1;
        step();
        err_clr = 0;
        chk("err_clr2", {31'b0, err}, 32'h0);

        // SPU read in flight at reset is discarded
        ren = 1; raddr = 12'h020;
        step();
        ren = 0; rst = 1;
        step();
        rst = 0;
        chk("flush_lbuf", rdata, 32'h0);
        step();
        chk("flush_lbuf_late", rdata, 32'h0);

        // host read in flight at reset is discarded; storage retained
        hv = 1; hwe = 0; haddr = 12'h010;
        #1 chk("pre_rst_ready", {31'b0, hready}, 32'h1);
        step();
        hv = 0; rst = 1;
        wen = 1; waddr = 12'h010; wdata = 32'h0BAD;
        #1 chk("in_rst_ready", {31'b0, hready}, 32'h0);
        step();
        wen = 0; rst = 0;
        for (int i = 0; i < 4; i++) begin
            chk("flush_host", {31'b0, hrvalid}, 32'h0);
            step();
        end
        ren = 1; raddr = 12'h010;
        step();
        ren = 0;
        step();
        chk("retained", rdata, 32'hA5A5_0001);

        // host writes 0..7, one stalled by an SPU write
        for (int i = 0; i < 8; i++) begin
            hv = 1; hwe = 1; haddr = AW'(i); hwdata = 32'h100 + i;
            if (i == 3) begin
                wen = 1; waddr = 12'h040; wdata = 32'h40;
                #1 chk("host_wr_stall", {31'b0, hready}, 32'h0);
                step();
                wen = 0;
            end
            step();
        end
        hv = 0;

        // back-to-back SPU reads
        for (int i = 0; i < 8; i++) begin
            ren = 1; raddr = AW'(i);
            step();
            if (i > 0) chk("stream", rdata, 32'h100 + i - 1);
        end
        ren = 0;
        step();
        chk("stream_last", rdata, 32'h107);

        // mixed traffic, model-checked
        for (int i = 0; i < 200; i++) begin
            ren     = ($urandom_range(0, 2) == 0);
            raddr   = ($urandom_range(0, 15) == 0) ? 12'h400 : AW'($urandom_range(0, 15));
            wen     = ($urandom_range(0, 2) == 0);
            waddr   = ($urandom_range(0, 15) == 0) ? 12'h401 : AW'($urandom_range(0, 15));
            wdata   = $urandom;
            hv      = ($urandom_range(0, 1) == 0);
            hwe     = ($urandom_range(0, 1) == 0);
            haddr   = AW'($urandom_range(0, 15));
            hwdata  = $urandom;
            err_clr = ($urandom_range(0, 7) == 0);
            step();
        end
        ren = 0; wen = 0; hv = 0; err_clr = 0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
